// File: rtl/equiv_pkg.sv
// Shared types and default parameters for the exhaustive equivalence sweeper.
package equiv_pkg;

    localparam int unsigned NIN_DEFAULT    = 4;
    localparam int unsigned SETTLE_DEFAULT = 1;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        CHECK,
        DONE
    } state_t;

endpackage

// File: rtl/equiv_sweeper_settle_timer.sv
// Settle down-counter: load presets SETTLE-1, enable counts toward zero and holds there.
module settle_timer #(
    parameter int unsigned SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic zero
);

    localparam int unsigned W = $clog2(SETTLE) + 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(SETTLE - 1);
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/equiv_sweeper.sv
// Steps vec through all 2^NIN values, compares ref_f against dut_f after each settle
// window, and reports mismatch count, first failing vector and a pass flag.
module equiv_sweeper
    import equiv_pkg::*;
#(
    parameter int unsigned NIN    = NIN_DEFAULT,
    parameter int unsigned SETTLE = SETTLE_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    input  logic           stop_on_fail,
    output logic [NIN-1:0] vec,
    input  logic           ref_f,
    input  logic           dut_f,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [NIN:0]   mismatches,
    output logic           fail_valid,
    output logic [NIN-1:0] first_fail
);

    state_t       state;
    logic         sof_q;
    logic         mis;
    logic         last;
    logic         launch;
    logic [NIN:0] mism_next;
    logic         timer_load;
    logic         timer_en;
    logic         timer_zero;

    assign mis       = ref_f ^ dut_f;
    assign last      = (vec == '1) || (sof_q && mis);
    assign mism_next = mismatches + (NIN+1)'(mis);
    assign launch    = ((state == IDLE) || (state == DONE)) && start && !abort;

    // Timer reloads on sweep launch and whenever CHECK hands over to the next vector.
    assign timer_load = launch || ((state == CHECK) && !abort && !last);
    assign timer_en   = (state == APPLY) && !abort;

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .enable (timer_en),
        .zero   (timer_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sof_q      <= 1'b0;
            vec        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            mismatches <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (abort) begin
                        state <= IDLE;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end else if (start) begin
                        state      <= APPLY;
                        sof_q      <= stop_on_fail;
                        vec        <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        mismatches <= '0;
                        fail_valid <= 1'b0;
                        first_fail <= '0;
                    end
                end
                APPLY: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (timer_zero) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (mis) begin
                            mismatches <= mism_next;
                            if (!fail_valid) begin
                                first_fail <= vec;
                                fail_valid <= 1'b1;
                            end
                        end
                        if (last) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (mism_next == '0);
                        end else begin
                            state <= APPLY;
                            vec   <= vec + NIN'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/equiv_sweeper.md
# equiv_sweeper

Exhaustive equivalence-check sequencer for small combinational blocks. It steps an input vector through all 2^NIN values and drives them to two implementations: a reference form and a transformed form, for example a sum-of-products circuit and its NAND-NAND rewrite. After each vector settles, it compares the two single-bit outputs. It reports the mismatch count, the first failing vector and a pass flag. It sits above the two circuit instances and replaces hand-written stimulus lists.

## Interface
Parameters:
- NIN, 4: number of input bits driven; the sweep covers 2^NIN vectors; NIN ≥ 1.
- SETTLE, 1: cycles each vector is held before the compare; SETTLE ≥ 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- abort  in  1  cancel a running sweep; return to IDLE.
- stop_on_fail  in  1  sampled with start; if 1, the sweep ends at the first mismatch.
- vec  out  NIN  stimulus vector; bit NIN-1 drives the first circuit input (a), bit 0 the last.
- ref_f  in  1  output of the reference implementation.
- dut_f  in  1  output of the transformed implementation.
- busy  out  1  high in APPLY and CHECK.
- done  out  1  high in DONE; held until the next start, an abort or a reset.
- pass  out  1  valid while done; 1 iff mismatches == 0.
- mismatches  out  NIN+1  number of vectors where ref_f != dut_f.
- fail_valid  out  1  at least one mismatch has been recorded this sweep.
- first_fail  out  NIN  first vector with a mismatch; valid when fail_valid = 1.

## Operation
- States:
  - IDLE: after reset or abort.
  - APPLY: vec held stable for SETTLE cycles.
  - CHECK: one cycle; compare ref_f against dut_f.
  - DONE: results held.
- IDLE or DONE with start = 1:
  - vec ← 0; mismatches, fail_valid, first_fail, pass, done ← 0.
  - Latch stop_on_fail.
  - Enter APPLY with the settle counter set to SETTLE-1.
- APPLY: the counter decrements; at 0 go to CHECK.
- CHECK with ref_f != dut_f:
  - mismatches increments.
  - If fail_valid = 0: first_fail ← vec and fail_valid ← 1.
- CHECK exit:
  - Go to DONE if vec == 2^NIN-1, or if (latched stop_on_fail and mismatch this cycle).
  - Otherwise vec increments and the state returns to APPLY with the counter reloaded.
- Entering DONE: done ← 1, pass ← (final mismatch count == 0); vec holds its last value.
- mismatches is NIN+1 bits wide, so it never wraps (maximum 2^NIN). vec does not wrap: the terminal compare ends the sweep.
- Priority while busy: abort > sweep.
  - abort forces IDLE next cycle with busy = 0 and done = 0; mismatches, fail_valid and first_fail keep their partial values.
  - start during busy is ignored.
- start and abort together in IDLE or DONE: abort wins; the state stays or becomes IDLE.

## Timing
- Reset (asynchronous, immediate, also mid-sweep): state IDLE, vec 0, busy 0, done 0, pass 0, mismatches 0, fail_valid 0, first_fail 0.
- start sampled at edge T: busy = 1 and vec = 0 from T+1.
- Each vector occupies SETTLE+1 cycles: SETTLE in APPLY, 1 in CHECK.
- Full sweep: busy is high for 2^NIN·(SETTLE+1) cycles; done rises on the cycle after the last CHECK and busy falls on the same cycle.
  - NIN = 4, SETTLE = 1: busy for 32 cycles, done at T+33.
- ref_f and dut_f are sampled only in CHECK. They are assumed to settle combinationally within SETTLE cycles of a vec change.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package equiv_pkg:
  - typedef for the state enum (IDLE, APPLY, CHECK, DONE).
  - Default constants for NIN and SETTLE.
- Sub-module settle_timer:
  - Down-counter of width clog2(SETTLE)+1.
  - Inputs load/enable; output zero.
  - Instantiated once.
- Vector counter, compare and result registers live in the top level.

## Test plan
- Equivalent pair (dut_f = ref_f = (a&b)|(c&d)), NIN 4, SETTLE 1, start pulse → busy 32 cycles; vec sequences 0…15, each held 2 cycles; done = 1, pass = 1, mismatches = 0, fail_valid = 0.
- Faulty dut_f inverted at vectors 5 and 11 only → done, pass = 0, mismatches = 2, first_fail = 5, fail_valid = 1.
- Same fault with stop_on_fail = 1 → done after the CHECK of vector 5; busy high 12 cycles; mismatches = 1, first_fail = 5.
- start re-asserted at vector 3 while busy → ignored; sweep completes normally. abort at vector 7 → IDLE next cycle, busy = 0, done = 0.
- rst_n pulled low mid-sweep at vector 9 → all outputs zero immediately. A later start runs a full clean sweep.
- SETTLE = 3 → each vector held 4 cycles; busy for 64 cycles; results identical to the first scenario.
